// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-to-AXI3 bridge and its helpers.
// Pure declarations: no timing and no flow control of its own.
package cpu_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RADDR,
      ST_RDATA,
      ST_WREQ,
      ST_WRESP
   } state_t;

   localparam logic [3:0] ID_INST = 4'd0;
   localparam logic [3:0] ID_DATA = 4'd1;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [1:0] INCR = 2'b01;

   // owner: 1 = data port, 0 = instruction port
   typedef struct packed {
      logic        owner;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe from access size and low address bits; purely combinational,
// zero latency, no flow control.
module axi_wstrb_gen
   import cpu_axi_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] wstrb
);

   always_comb begin
      wstrb = 4'b1111;
      case (size)
         SZ_B:    wstrb = 4'b0001 << addr_lo;
         SZ_H:    wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: wstrb = 4'b1111;
      endcase
   end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Two sram-like CPU ports onto one AXI3 master, one transaction outstanding, data before fetch.
// Accept in IDLE only; read data_ok >= 2 cycles after addr_ok; AXI stalls hold the FSM in place.
module cpu_axi_bridge
   import cpu_axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,

   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,

   output logic [DATA_W-1:0] cpu_rdata,

   output logic [3:0]        arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [2:0]        arsize,
   output logic              arvalid,
   input  logic              arready,

   input  logic [3:0]        rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rvalid,
   output logic              rready,

   output logic [3:0]        awid,
   output logic [ADDR_W-1:0] awaddr,
   output logic [2:0]        awsize,
   output logic              awvalid,
   input  logic              awready,

   output logic [DATA_W-1:0] wdata,
   output logic [3:0]        wstrb,
   output logic              wvalid,
   input  logic              wready,

   input  logic              bvalid,
   output logic              bready
);

   state_t state_q, state_d;
   req_t   req_q, req_d;
   logic   aw_done_q, aw_done_d;
   logic   w_done_q, w_done_d;

   // Responses are matched by the single-outstanding rule, so rid carries no information.
   logic   unused_ok;
   assign  unused_ok = ^rid;

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      arvalid      = 1'b0;
      rready       = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      bready       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (resetn && data_req) begin
               data_addr_ok = 1'b1;
               req_d.owner  = 1'b1;
               req_d.wr     = data_wr;
               req_d.size   = data_size;
               req_d.addr   = data_addr;
               req_d.wdata  = data_wdata;
               aw_done_d    = 1'b0;
               w_done_d     = 1'b0;
               state_d      = data_wr ? ST_WREQ : ST_RADDR;
            end else if (resetn && inst_req) begin
               inst_addr_ok = 1'b1;
               req_d.owner  = 1'b0;
               req_d.wr     = 1'b0;
               req_d.size   = SZ_W;
               req_d.addr   = inst_addr;
               req_d.wdata  = '0;
               state_d      = ST_RADDR;
            end
         end
         ST_RADDR: begin
            arvalid = 1'b1;
            if (arready) state_d = ST_RDATA;
         end
         ST_RDATA: begin
            rready = 1'b1;
            if (rvalid) begin
               inst_data_ok = ~req_q.owner;
               data_data_ok = req_q.owner;
               state_d      = ST_IDLE;
            end
         end
         ST_WREQ: begin
            // AW and W complete independently; leave only once both beats are gone.
            awvalid   = ~aw_done_q;
            wvalid    = ~w_done_q;
            aw_done_d = aw_done_q | awready;
            w_done_d  = w_done_q | wready;
            if (aw_done_d && w_done_d) state_d = ST_WRESP;
         end
         ST_WRESP: begin
            bready = 1'b1;
            if (bvalid) begin
               data_data_ok = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign arid      = req_q.owner ? ID_DATA : ID_INST;
   assign araddr    = req_q.addr;
   assign arsize    = {1'b0, req_q.size};
   assign awid      = ID_DATA;
   assign awaddr    = req_q.addr;
   assign awsize    = {1'b0, req_q.size};
   assign wdata     = req_q.wdata;
   assign cpu_rdata = rdata;

   axi_wstrb_gen u_wstrb (
      .size    (req_q.size),
      .addr_lo (req_q.addr[1:0]),
      .wstrb   (wstrb)
   );

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed stimulus with a scoreboard queue; a negedge monitor checks every AXI handshake and data_ok.
module tb_cpu_axi_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, data_req, data_wr;
   logic [31:0] inst_addr, data_addr, data_wdata;
   logic [1:0]  data_size;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] cpu_rdata;
   logic [3:0]  arid, rid, awid, wstrb;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;

   always #5 clk = ~clk;

   cpu_axi_bridge dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .cpu_rdata(cpu_rdata),
      .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   localparam int EV_AR = 0, EV_AW = 1, EV_W = 2, EV_IOK = 3, EV_DOK = 4, EV_DOKW = 5;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [3:0]  id;
      logic [3:0]  sz;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   int  ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;

   function automatic void push(input int kind, input logic [31:0] a,
                                input logic [3:0] id, input logic [3:0] sz);
      ev_t e;
      e.kind = kind; e.a = a; e.id = id; e.sz = sz;
      exp_q.push_back(e);
   endfunction

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      if (a == 32'hBFC0_0000) return 32'h3C1D_BFC0;
      return a ^ 32'hA5A5_A5A5;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic mon(input int kind, input logic [31:0] a, input logic [3:0] id, input logic [3:0] sz);
      ev_t e;
      bit  ok;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL monitor_unexpected: got event %0d a=%h id=%h sz=%h, expected none", kind, a, id, sz);
      end else begin
         e = exp_q.pop_front();
         if (kind == EV_DOK && e.kind == EV_DOKW) ok = 1'b1;
         else ok = (e.kind == kind) && (e.a === a) && (e.id === id) && (e.sz === sz);
         if (!ok) begin
            n_err++;
            $display("FAIL monitor_event: got kind %0d a=%h id=%h sz=%h expected kind %0d a=%h id=%h sz=%h",
                     kind, a, id, sz, e.kind, e.a, e.id, e.sz);
         end
      end
   endtask

   always @(negedge clk) begin
      if (arvalid && arready) mon(EV_AR, araddr, arid, {1'b0, arsize});
      if (awvalid && awready) mon(EV_AW, awaddr, awid, {1'b0, awsize});
      if (wvalid && wready)   mon(EV_W, wdata, 4'd0, wstrb);
      if (inst_data_ok)       mon(EV_IOK, cpu_rdata, 4'd0, 4'd0);
      if (data_data_ok)       mon(EV_DOK, cpu_rdata, 4'd0, 4'd0);
   end

   always @(negedge clk) begin
      if (resetn && data_req)
         assert (data_size != 2'd3) else $error("illegal data_size=3 presented to bridge");
   end

   // AXI slave model: read address then read data
   initial begin
      logic [31:0] sl_addr;
      logic [3:0]  sl_id;
      arready = 0; rvalid = 0; rdata = 0; rid = 0;
      forever begin
         @(posedge clk); #1;
         if (arvalid) begin
            for (int i = 0; i < ar_delay; i++) begin @(posedge clk); #1; end
            arready = 1; sl_addr = araddr; sl_id = arid;
            @(posedge clk); #1; arready = 0;
            for (int i = 0; i < r_delay; i++) begin @(posedge clk); #1; end
            rvalid = 1; rdata = rd_model(sl_addr); rid = sl_id;
            @(posedge clk); #1; rvalid = 0;
         end
      end
   end

   initial begin
      awready = 0;
      forever begin
         @(posedge clk); #1;
         if (awvalid) begin
            for (int i = 0; i < aw_delay; i++) begin @(posedge clk); #1; end
            awready = 1;
            @(posedge clk); #1; awready = 0;
         end
      end
   end

   initial begin
      wready = 0;
      forever begin
         @(posedge clk); #1;
         if (wvalid) begin
            for (int i = 0; i < w_delay; i++) begin @(posedge clk); #1; end
            wready = 1;
            @(posedge clk); #1; wready = 0;
         end
      end
   end

   initial begin
      bvalid = 0;
      forever begin
         @(posedge clk); #1;
         if (bready) begin
            for (int i = 0; i < b_delay; i++) begin @(posedge clk); #1; end
            bvalid = 1;
            @(posedge clk); #1; bvalid = 0;
         end
      end
   end

   function automatic bit flag(input int sel);
      case (sel)
         0:       return inst_addr_ok;
         1:       return data_addr_ok;
         2:       return inst_data_ok;
         default: return data_data_ok;
      endcase
   endfunction

   task automatic wait_flag(input string nm, input int sel, input int bud);
      bit hit = 0;
      for (int k = 0; k < bud; k++) begin
         @(negedge clk);
         if (flag(sel)) begin hit = 1; break; end
      end
      chk(nm, {31'd0, hit}, 32'd1);
   endtask

   // inst_req is held high; the fetch must not be accepted before data_data_ok
   task automatic wait_fetch_after_data(input string nm, input int bud);
      bit seen = 0;
      bit hit  = 0;
      for (int k = 0; k < bud; k++) begin
         @(negedge clk);
         if (data_data_ok) seen = 1;
         if (inst_addr_ok) begin hit = 1; break; end
      end
      chk({nm, "_accepted"}, {31'd0, hit}, 32'd1);
      chk({nm, "_after_data_ok"}, {31'd0, seen}, 32'd1);
   endtask

   task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      data_req = 1; data_wr = 1; data_size = sz; data_addr = a; data_wdata = d;
      wait_flag("store_addr_ok", 1, 20);
      @(posedge clk); #1;
      data_req = 0; data_addr = 32'hDEAD_0000; data_wdata = 32'h0;
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 0; inst_req = 0; inst_addr = 0;
      data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h10; data_wdata = 0;
      repeat (3) @(negedge clk);
      chk("reset_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd0);
      chk("reset_valids", {25'd0, arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}, 32'd0);
      @(posedge clk); #1;
      data_req = 0; resetn = 1;
      repeat (2) @(posedge clk);

      // 1: single fetch
      ar_delay = 0; r_delay = 2;
      push(EV_AR, 32'hBFC0_0000, 4'd0, 4'd2);
      push(EV_IOK, 32'h3C1D_BFC0, 4'd0, 4'd0);
      @(posedge clk); #1;
      inst_req = 1; inst_addr = 32'hBFC0_0000;
      wait_flag("fetch_addr_ok", 0, 20);
      @(posedge clk); #1;
      inst_addr = 32'h0000_0000;
      @(negedge clk);
      chk("fetch_addr_ok_one_cycle", {31'd0, inst_addr_ok}, 32'd0);
      @(posedge clk); #1;
      inst_req = 0;
      wait_flag("fetch_data_ok", 2, 20);

      // 2: data has priority over fetch
      r_delay = 0;
      push(EV_AR, 32'h0000_0010, 4'd1, 4'd2);
      push(EV_DOK, 32'hA5A5_A5B5, 4'd0, 4'd0);
      push(EV_AR, 32'hBFC0_0004, 4'd0, 4'd2);
      push(EV_IOK, 32'h1A65_A5A1, 4'd0, 4'd0);
      @(posedge clk); #1;
      inst_req = 1; inst_addr = 32'hBFC0_0004;
      data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h10;
      @(negedge clk);
      chk("prio_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
      chk("prio_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
      @(posedge clk); #1;
      data_req = 0;
      wait_fetch_after_data("prio_fetch", 30);
      @(posedge clk); #1;
      inst_req = 0;
      wait_flag("prio_fetch_data_ok", 2, 20);

      // 3: narrow stores
      push(EV_AW, 32'h0000_1003, 4'd1, 4'd0);
      push(EV_W, 32'h0000_00AB, 4'd0, 4'b1000);
      push(EV_DOKW, 32'h0, 4'd0, 4'd0);
      do_store(2'd0, 32'h1003, 32'h0000_00AB);
      wait_flag("byte_store_done", 3, 20);
      push(EV_AW, 32'h0000_1002, 4'd1, 4'd1);
      push(EV_W, 32'h0000_CDEF, 4'd0, 4'b1100);
      push(EV_DOKW, 32'h0, 4'd0, 4'd0);
      do_store(2'd1, 32'h1002, 32'h0000_CDEF);
      wait_flag("half_store_done", 3, 20);
      push(EV_AW, 32'h0000_1001, 4'd1, 4'd0);
      push(EV_W, 32'h0000_5A00, 4'd0, 4'b0010);
      push(EV_DOKW, 32'h0, 4'd0, 4'd0);
      do_store(2'd0, 32'h1001, 32'h0000_5A00);
      wait_flag("byte1_store_done", 3, 20);

      // 4: W handshake three cycles ahead of AW
      w_delay = 0; aw_delay = 3;
      push(EV_W, 32'hDEAD_BEEF, 4'd0, 4'b1111);
      push(EV_AW, 32'h0000_2000, 4'd1, 4'd2);
      push(EV_DOKW, 32'h0, 4'd0, 4'd0);
      do_store(2'd2, 32'h2000, 32'hDEAD_BEEF);
      begin
         bit hit = 0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wvalid && wready) begin hit = 1; break; end
         end
         chk("split_w_handshake", {31'd0, hit}, 32'd1);
      end
      @(negedge clk);
      chk("split_wvalid_dropped", {31'd0, wvalid}, 32'd0);
      chk("split_awvalid_held", {31'd0, awvalid}, 32'd1);
      wait_flag("split_store_done", 3, 30);
      aw_delay = 0;

      // 5: AR backpressure while a fetch waits
      ar_delay = 5;
      push(EV_AR, 32'h0000_0040, 4'd1, 4'd1);
      push(EV_DOK, 32'hA5A5_A5E5, 4'd0, 4'd0);
      push(EV_AR, 32'hBFC0_0008, 4'd0, 4'd2);
      push(EV_IOK, 32'h1A65_A5AD, 4'd0, 4'd0);
      @(posedge clk); #1;
      data_req = 1; data_wr = 0; data_size = 2'd1; data_addr = 32'h40;
      wait_flag("bp_addr_ok", 1, 20);
      @(posedge clk); #1;
      data_req = 0; data_addr = 32'hFFFF_FFF0;
      inst_req = 1; inst_addr = 32'hBFC0_0008;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_arvalid", {31'd0, arvalid}, 32'd1);
         chk("bp_araddr", araddr, 32'h0000_0040);
         chk("bp_no_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      end
      wait_fetch_after_data("bp_fetch", 40);
      @(posedge clk); #1;
      inst_req = 0;
      wait_flag("bp_fetch_data_ok", 2, 40);
      ar_delay = 0;

      // 6: reset while stuck in the write-request phase
      aw_delay = 8; w_delay = 8;
      do_store(2'd2, 32'h3000, 32'h1234_5678);
      @(negedge clk);
      chk("rst_in_wreq", {30'd0, awvalid, wvalid}, 32'd3);
      @(posedge clk); #1;
      resetn = 0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_valids_clear", {25'd0, arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}, 32'd0);
      @(posedge clk); #1;
      resetn = 1;
      repeat (12) @(posedge clk);
      aw_delay = 0; w_delay = 0;
      push(EV_AR, 32'h0000_0080, 4'd1, 4'd0);
      push(EV_DOK, 32'hA5A5_A525, 4'd0, 4'd0);
      @(posedge clk); #1;
      data_req = 1; data_wr = 0; data_size = 2'd0; data_addr = 32'h80;
      @(negedge clk);
      chk("post_rst_idle_accept", {31'd0, data_addr_ok}, 32'd1);
      @(posedge clk); #1;
      data_req = 0;
      wait_flag("post_rst_load_done", 3, 20);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
Converts the CPU's two sram-like ports (instruction fetch, data access) into a single AXI3 master. It sits directly downstream of mycpu_top and feeds the SoC interconnect. At most one transaction is outstanding at any time. A pending data request has priority over a pending instruction request.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; strobe logic assumes 4 bytes)

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
inst_req  in  1  fetch request (read-only, word size)
inst_addr  in  32  fetch byte address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data valid this cycle
data_req  in  1  data request
data_wr  in  1  1=store, 0=load
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  32  data byte address
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  load data returned / store completed this cycle
cpu_rdata  out  32  read data, shared by both ports, qualified by *_data_ok
AR channel  out  arid[3:0], araddr[31:0], arsize[2:0], arvalid; in arready
R channel  in  rid[3:0], rdata[31:0], rvalid; out rready
AW channel  out  awid[3:0], awaddr[31:0], awsize[2:0], awvalid; in awready
W channel  out  wdata[31:0], wstrb[3:0], wvalid; in wready
B channel  in  bvalid; out bready
(len=0, burst=INCR, lock/cache/prot are tied off at the SoC top, not here.)

Behaviour:
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP.
- Reset: state=IDLE; all valid/ready outputs=0; addr_ok and data_ok outputs=0. Reset mid-transaction aborts immediately with no drain.
- Acceptance in IDLE, combinational:
  - data_addr_ok = IDLE & data_req.
  - inst_addr_ok = IDLE & inst_req & ~data_req.
  - Both addr_ok outputs are 0 in every other state.
- On acceptance, latch the request into registers: owner, wr, size, addr, wdata.
  - Load or fetch -> RADDR. Store -> WREQ.
- RADDR:
  - arvalid=1, araddr=latched addr, arsize={1'b0,size} (fetch uses 2).
  - arid=0 for inst, 1 for data.
  - On arready -> RDATA; arvalid drops the same edge.
- RDATA:
  - rready=1.
  - On rvalid: assert owner's *_data_ok for exactly that cycle; cpu_rdata=rdata (pass-through, full word, no shifting); -> IDLE.
  - rid is not checked.
- WREQ:
  - awvalid and wvalid both asserted on entry.
  - Each drops independently after its own handshake; handshakes may occur in either order or the same cycle.
  - When both are done -> WRESP.
  - awid=1; wdata=latched wdata.
  - wstrb: size0 -> 4'b0001<<addr[1:0]; size1 -> addr[1]?4'b1100:4'b0011; size2 -> 4'b1111.
- WRESP:
  - bready=1.
  - On bvalid: data_data_ok=1 for one cycle -> IDLE. bresp is ignored.
- Latency (zero-wait slave): read = 1 cycle accept + AR + R, so data_ok is ≥2 cycles after addr_ok. Write ≥2 cycles likewise.
- Back-to-back: a new request may be accepted in the cycle after data_ok (IDLE is re-entered).
- Address/data inputs are sampled only in the acceptance cycle; later changes are ignored.
- data_size=3 is illegal; its behaviour is undefined and must be flagged by a bench assertion.

Decomposition:
- Shared package cpu_axi_pkg:
  - state encoding constants.
  - ID constants ID_INST=0, ID_DATA=1.
  - size encodings SZ_B/SZ_H/SZ_W.
  - burst constant INCR=2'b01.
- One natural sub-module, axi_wstrb_gen (size + addr[1:0] -> wstrb), reusable later by a cache write path.

Test Plan:
1. Single fetch:
   - Stimulus: inst_req=1, addr=0xBFC00000; slave arready after 0 cycles, rvalid after 2 cycles with rdata=0x3C1DBFC0.
   - Required: inst_addr_ok for 1 cycle; arid=0, arsize=2; inst_data_ok for exactly 1 cycle with cpu_rdata=0x3C1DBFC0.
2. Priority:
   - Stimulus: inst_req and data_req (load, addr 0x10) both high in IDLE.
   - Required: data_addr_ok=1, inst_addr_ok=0; arid=1 first. The fetch is accepted only after data_data_ok.
3. Byte store:
   - Stimulus: size=0, addr=0x1003, wdata=0xAB.
   - Required: wstrb=4'b1000, awsize=0, awid=1; data_data_ok on bvalid. Half store at 0x1002 -> wstrb=4'b1100.
4. Split handshakes:
   - Stimulus: wready precedes awready by 3 cycles.
   - Required: wvalid drops after its handshake, awvalid stays high until awready, no duplicate W beat, a single data_ok.
5. Backpressure:
   - Stimulus: arready held low for 5 cycles.
   - Required: arvalid and araddr stable throughout; no addr_ok for a new request while busy.
6. Reset mid-write:
   - Stimulus: resetn low while in WREQ.
   - Required: next cycle all valid outputs=0, state=IDLE, no data_ok.
